// File: rtl/ccff_chain_loader.sv
// rtl/ccff_chain_loader.sv - configuration-chain segment loader with CRC-8 readback verify
//
// Loads one ccff_head -> ccff_tail chain segment from a stream of bitstream
// words, then recirculates the chain once (tail -> head) while comparing the
// CRC-8 of the tail stream against the CRC-8 of the bits that were loaded.
//
// Ports:
//   prog_clk      programming clock, all state on the rising edge
//   pReset        asynchronous active-low reset
//   start         one-cycle pulse, begins a load when idle
//   cfg_data      bitstream word, bit 0 shifted first
//   cfg_valid     cfg_data valid
//   cfg_ready     word accepted when cfg_valid & cfg_ready
//   ccff_head     serial bit into the chain head
//   ccff_shift_en chain captures ccff_head on the next prog_clk edge
//   ccff_tail     serial bit from the chain tail
//   busy          high while loading or verifying
//   done          one-cycle pulse when verify completes
//   err           CRC mismatch, held until the next accepted start

module ccff_crc8_step (
    input  logic [7:0] crc_in,
    input  logic       bit_in,
    output logic [7:0] crc_out
);
    logic fb;

    assign fb      = crc_in[7] ^ bit_in;
    assign crc_out = {crc_in[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
endmodule

module ccff_chain_loader #(
    parameter int CHAIN_LEN = 9,
    parameter int WORD_W    = 8,
    parameter int CNT_W     = 16
) (
    input  logic              prog_clk,
    input  logic              pReset,
    input  logic              start,
    input  logic [WORD_W-1:0] cfg_data,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    output logic              ccff_head,
    output logic              ccff_shift_en,
    input  logic              ccff_tail,
    output logic              busy,
    output logic              done,
    output logic              err
);
    localparam int REM_W = $clog2(WORD_W + 1);
    localparam logic [CNT_W-1:0] CHAIN_C  = CNT_W'(CHAIN_LEN);
    localparam logic [CNT_W-1:0] WORDS_C  = CNT_W'((CHAIN_LEN + WORD_W - 1) / WORD_W);
    localparam logic [REM_W-1:0] REM_FULL = REM_W'(WORD_W);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_VERIFY,
        S_DONE
    } state_t;

    state_t            state_q,     state_d;
    logic [WORD_W-1:0] hold_q,      hold_d;
    logic              hold_full_q, hold_full_d;
    logic [WORD_W-1:0] shreg_q,     shreg_d;
    logic [REM_W-1:0]  rem_q,       rem_d;
    logic [CNT_W-1:0]  words_q,     words_d;
    logic [CNT_W-1:0]  bit_cnt_q,   bit_cnt_d;
    logic [CNT_W-1:0]  ver_cnt_q,   ver_cnt_d;
    logic [7:0]        load_crc_q,  load_crc_d;
    logic [7:0]        ver_crc_q,   ver_crc_d;
    logic              head_q,      head_d;
    logic              shift_en_q,  shift_en_d;
    logic              recirc_q,    recirc_d;
    logic              err_q,       err_d;

    logic              shift_fire;
    logic              shift_bit;
    logic [7:0]        load_crc_nxt;
    logic [7:0]        ver_crc_nxt;

    ccff_crc8_step u_load_crc (
        .crc_in  (load_crc_q),
        .bit_in  (shift_bit),
        .crc_out (load_crc_nxt)
    );

    ccff_crc8_step u_ver_crc (
        .crc_in  (ver_crc_q),
        .bit_in  (ccff_tail),
        .crc_out (ver_crc_nxt)
    );

    // Ready depends only on registered state, never on cfg_valid.
    assign cfg_ready     = (state_q == S_LOAD) && !hold_full_q && (words_q < WORDS_C);
    // recirc_q marks a verify shift cycle: the chain feeds itself tail -> head.
    assign ccff_head     = recirc_q ? ccff_tail : head_q;
    assign ccff_shift_en = shift_en_q;
    assign busy          = (state_q == S_LOAD) || (state_q == S_VERIFY);
    assign done          = (state_q == S_DONE);
    assign err           = err_q;

    always_comb begin
        state_d     = state_q;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        shreg_d     = shreg_q;
        rem_d       = rem_q;
        words_d     = words_q;
        bit_cnt_d   = bit_cnt_q;
        ver_cnt_d   = ver_cnt_q;
        load_crc_d  = load_crc_q;
        ver_crc_d   = ver_crc_q;
        err_d       = err_q;
        head_d      = 1'b0;
        shift_en_d  = 1'b0;
        recirc_d    = 1'b0;
        shift_fire  = 1'b0;
        shift_bit   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d     = S_LOAD;
                    err_d       = 1'b0;
                    hold_d      = '0;
                    hold_full_d = 1'b0;
                    shreg_d     = '0;
                    rem_d       = '0;
                    words_d     = '0;
                    bit_cnt_d   = '0;
                    ver_cnt_d   = '0;
                    load_crc_d  = 8'h00;
                    ver_crc_d   = 8'h00;
                end
            end

            S_LOAD: begin
                if (cfg_valid && cfg_ready) begin
                    hold_d      = cfg_data;
                    hold_full_d = 1'b1;
                    words_d     = words_q + CNT_W'(1);
                end

                if (bit_cnt_q == CHAIN_C) begin
                    // Whole segment shifted; leftover word bits are dropped and
                    // the first recirculating shift is issued straight away.
                    state_d    = S_VERIFY;
                    shift_en_d = 1'b1;
                    recirc_d   = 1'b1;
                    ver_cnt_d  = CNT_W'(1);
                end else if (rem_q != '0) begin
                    shift_fire = 1'b1;
                    shift_bit  = shreg_q[0];
                    shreg_d    = shreg_q >> 1;
                    rem_d      = rem_q - REM_W'(1);
                    // Reload on the last bit so a waiting word follows gaplessly.
                    if ((rem_q == REM_W'(1)) && hold_full_q) begin
                        shreg_d     = hold_q;
                        rem_d       = REM_FULL;
                        hold_full_d = 1'b0;
                    end
                end else if (hold_full_q) begin
                    // Shift register empty: take bit 0 directly from the hold reg.
                    shift_fire  = 1'b1;
                    shift_bit   = hold_q[0];
                    shreg_d     = hold_q >> 1;
                    rem_d       = REM_FULL - REM_W'(1);
                    hold_full_d = 1'b0;
                end

                if (shift_fire) begin
                    head_d     = shift_bit;
                    shift_en_d = 1'b1;
                    bit_cnt_d  = bit_cnt_q + CNT_W'(1);
                    load_crc_d = load_crc_nxt;
                end
            end

            S_VERIFY: begin
                // The tail bit captured by the shift now completing is folded in.
                if (recirc_q) begin
                    ver_crc_d = ver_crc_nxt;
                end
                if (ver_cnt_q < CHAIN_C) begin
                    shift_en_d = 1'b1;
                    recirc_d   = 1'b1;
                    ver_cnt_d  = ver_cnt_q + CNT_W'(1);
                end else begin
                    state_d = S_DONE;
                    err_d   = (load_crc_q != ver_crc_d);
                end
            end

            S_DONE: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge prog_clk or negedge pReset) begin
        if (!pReset) begin
            state_q     <= S_IDLE;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            shreg_q     <= '0;
            rem_q       <= '0;
            words_q     <= '0;
            bit_cnt_q   <= '0;
            ver_cnt_q   <= '0;
            load_crc_q  <= 8'h00;
            ver_crc_q   <= 8'h00;
            head_q      <= 1'b0;
            shift_en_q  <= 1'b0;
            recirc_q    <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            shreg_q     <= shreg_d;
            rem_q       <= rem_d;
            words_q     <= words_d;
            bit_cnt_q   <= bit_cnt_d;
            ver_cnt_q   <= ver_cnt_d;
            load_crc_q  <= load_crc_d;
            ver_crc_q   <= ver_crc_d;
            head_q      <= head_d;
            shift_en_q  <= shift_en_d;
            recirc_q    <= recirc_d;
            err_q       <= err_d;
        end
    end
endmodule

// File: tb/tb_ccff_chain_loader.sv
// tb/tb_ccff_chain_loader.sv - self-checking bench for ccff_chain_loader
`timescale 1ns/1ps
module tb_ccff_chain_loader;
    localparam int L  = 9;
    localparam int L2 = 16;
    localparam int W  = 8;

    logic prog_clk = 1'b0;
    always #5 prog_clk = ~prog_clk;

    logic         pReset;
    logic         start, cfg_valid, cfg_ready, ccff_head, ccff_shift_en, ccff_tail, busy, done, err;
    logic [W-1:0] cfg_data;
    logic         start2, cfg_valid2, cfg_ready2, ccff_head2, ccff_shift_en2, ccff_tail2, busy2, done2, err2;
    logic [W-1:0] cfg_data2;

    ccff_chain_loader #(.CHAIN_LEN(L), .WORD_W(W), .CNT_W(16)) dut (
        .prog_clk(prog_clk), .pReset(pReset), .start(start), .cfg_data(cfg_data),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .ccff_head(ccff_head),
        .ccff_shift_en(ccff_shift_en), .ccff_tail(ccff_tail), .busy(busy),
        .done(done), .err(err)
    );

    ccff_chain_loader #(.CHAIN_LEN(L2), .WORD_W(W), .CNT_W(16)) dut2 (
        .prog_clk(prog_clk), .pReset(pReset), .start(start2), .cfg_data(cfg_data2),
        .cfg_valid(cfg_valid2), .cfg_ready(cfg_ready2), .ccff_head(ccff_head2),
        .ccff_shift_en(ccff_shift_en2), .ccff_tail(ccff_tail2), .busy(busy2),
        .done(done2), .err(err2)
    );

    // Chain models; the first one can corrupt one tail bit during verify.
    logic [L-1:0]  chain  = '0;
    logic [L2-1:0] chain2 = '0;
    int cap_cnt = 0;
    int inv_at  = -1;
    int cyc     = 0;

    assign ccff_tail  = chain[L-1] ^ ((inv_at >= 0) && (cap_cnt == inv_at));
    assign ccff_tail2 = chain2[L2-1];

    always @(posedge prog_clk) begin
        cyc <= cyc + 1;
        if (ccff_shift_en) begin
            chain   <= {chain[L-2:0], ccff_head};
            cap_cnt <= cap_cnt + 1;
        end
        if (ccff_shift_en2) chain2 <= {chain2[L2-2:0], ccff_head2};
    end

    typedef struct {
        logic [W-1:0] w0;
        logic [W-1:0] w1;
        int           gap;
        int           inv;
        bit           poke;
        bit           exp_err;
    } vec_t;

    vec_t tbl[6];

    int   n_vec = 0;
    int   n_fail = 0;
    logic exp_q[$];
    bit   mon_chk = 1'b1;
    int   shift_cnt = 0, shift_base = 0, first_cyc = 0, last_cyc = 0;
    int   hs_cnt = 0, done_cnt = 0, done_cyc = 0;
    int   hs2_cnt = 0, done2_cnt = 0, done2_cyc = 0;
    logic prev_err = 1'b0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic monitor();
        logic e_bit;
        forever begin
            @(negedge prog_clk);
            if (ccff_shift_en) begin
                if (shift_cnt - shift_base == 0) first_cyc = cyc;
                if (shift_cnt - shift_base == L - 1) last_cyc = cyc;
                shift_cnt++;
                if (mon_chk) begin
                    if (exp_q.size() == 0) begin
                        n_vec++;
                        n_fail++;
                        $display("FAIL unexpected_shift: head %0b at cycle %0d, nothing expected", ccff_head, cyc);
                    end else begin
                        e_bit = exp_q.pop_front();
                        check("head_bit", {31'd0, ccff_head}, {31'd0, e_bit});
                    end
                end
            end
            if (cfg_valid && cfg_ready) hs_cnt++;
            if (done) begin done_cnt++; done_cyc = cyc; end
            if (cfg_valid2 && cfg_ready2) hs2_cnt++;
            if (done2) begin done2_cnt++; done2_cyc = cyc; end
        end
    endtask

    task automatic drive_word(input logic [W-1:0] w);
        int t;
        cfg_data  = w;
        cfg_valid = 1'b1;
        t = 0;
        do begin
            @(negedge prog_clk);
            t++;
        end while (!cfg_ready && t < 60);
        if (!cfg_ready) begin
            n_vec++;
            n_fail++;
            $display("FAIL word_accept: cfg_ready never rose for word %0h", w);
        end
        @(posedge prog_clk);
        #1;
        cfg_valid = 1'b0;
    endtask

    task automatic run_load(input vec_t v);
        logic [2*W-1:0] wd;
        logic [L-1:0]   exp_chain;
        int c0, hs_base, d_base, t, stall, pushed;
        wd    = {v.w1, v.w0};
        stall = (v.gap > 7) ? v.gap - 7 : 0;
        for (int i = 0; i < L; i++) exp_chain[L-1-i] = wd[i] ^ (i == v.inv);

        check("err_before_start", {31'd0, err}, {31'd0, prev_err});
        check("idle_busy", {31'd0, busy}, 32'd0);
        shift_base = shift_cnt;
        hs_base    = hs_cnt;
        d_base     = done_cnt;
        mon_chk    = 1'b1;
        inv_at     = (v.inv >= 0) ? cap_cnt + L + v.inv : -1;

        @(negedge prog_clk);
        start = 1'b1;
        @(posedge prog_clk);
        #1;
        start = 1'b0;
        c0 = cyc;
        check("err_clear_on_load", {31'd0, err}, 32'd0);
        check("busy_in_load", {31'd0, busy}, 32'd1);

        fork
            begin
                pushed = 0;
                for (int i = 0; i < W; i++) if (pushed < L) begin exp_q.push_back(v.w0[i]); pushed++; end
                drive_word(v.w0);
                if (v.gap > 0) begin
                    repeat (v.gap) @(posedge prog_clk);
                    #1;
                end
                for (int i = 0; i < W; i++) if (pushed < L) begin exp_q.push_back(v.w1[i]); pushed++; end
                drive_word(v.w1);
                for (int i = 0; i < L; i++) exp_q.push_back(wd[i] ^ (i == v.inv));
            end
            begin
                if (v.poke) begin
                    repeat (4) @(posedge prog_clk);
                    #1 start = 1'b1;
                    @(posedge prog_clk);
                    #1 start = 1'b0;
                    repeat (9) @(posedge prog_clk);
                    #1 start = 1'b1;
                    @(posedge prog_clk);
                    #1 start = 1'b0;
                end
            end
        join

        t = 0;
        while (done_cnt == d_base && t < 300) begin
            @(posedge prog_clk);
            #2;
            t++;
        end
        check("done_in_time", {31'd0, (t < 300)}, 32'd1);
        repeat (25) @(posedge prog_clk);
        #2;
        check("done_count", done_cnt - d_base, 1);
        check("done_latency", done_cyc - c0, 20 + stall);
        check("first_shift_latency", first_cyc - c0, 2);
        check("last_load_shift", last_cyc - c0, 10 + stall);
        check("shift_total", shift_cnt - shift_base, 2 * L);
        check("words_accepted", hs_cnt - hs_base, 2);
        check("err", {31'd0, err}, {31'd0, v.exp_err});
        check("sb_drained", exp_q.size(), 0);
        check("chain_contents", {23'd0, chain}, {23'd0, exp_chain});
        prev_err = v.exp_err;
        inv_at   = -1;
    endtask

    initial begin
        int t, c0, hs_base, d_base;
        logic rdy_late;
        logic [2*W-1:0] wd2;
        logic [L2-1:0]  exp_chain2;

        tbl[0] = '{8'hA5, 8'h01,  0, -1, 1'b0, 1'b0};
        tbl[1] = '{8'hA5, 8'h01, 10, -1, 1'b0, 1'b0};
        tbl[2] = '{8'h3C, 8'hFE,  0,  4, 1'b0, 1'b1};
        tbl[3] = '{8'hFF, 8'hFF,  3, -1, 1'b1, 1'b0};
        tbl[4] = '{8'h00, 8'h00, 12,  8, 1'b0, 1'b1};
        tbl[5] = '{8'h5A, 8'h81,  1,  0, 1'b1, 1'b1};

        pReset = 1'b0;
        start = 1'b0; cfg_valid = 1'b0; cfg_data = '0;
        start2 = 1'b0; cfg_valid2 = 1'b0; cfg_data2 = '0;
        fork monitor(); join_none

        repeat (3) @(posedge prog_clk);
        #2;
        check("reset_outs", {26'd0, cfg_ready, ccff_head, ccff_shift_en, busy, done, err}, 32'd0);
        check("reset_outs2", {26'd0, cfg_ready2, ccff_head2, ccff_shift_en2, busy2, done2, err2}, 32'd0);
        @(negedge prog_clk);
        pReset = 1'b1;

        for (int i = 0; i < 6; i++) run_load(tbl[i]);

        // Reset in the middle of a load, then a clean reload.
        mon_chk    = 1'b0;
        shift_base = shift_cnt;
        @(negedge prog_clk);
        start = 1'b1;
        @(posedge prog_clk);
        #1;
        start = 1'b0;
        cfg_data  = 8'hA5;
        cfg_valid = 1'b1;
        t = 0;
        while (shift_cnt - shift_base < 4 && t < 50) begin
            @(posedge prog_clk);
            #2;
            if (cfg_ready) cfg_valid = 1'b0;
            t++;
        end
        check("four_shifts_seen", {31'd0, (t < 50)}, 32'd1);
        pReset    = 1'b0;
        cfg_valid = 1'b0;
        #1;
        check("midload_reset_outs", {26'd0, cfg_ready, ccff_head, ccff_shift_en, busy, done, err}, 32'd0);
        @(negedge prog_clk);
        pReset   = 1'b1;
        prev_err = 1'b0;
        run_load(tbl[0]);

        // 16-bit chain: exactly two words taken, a third stays pending.
        wd2 = 16'hC33C;
        for (int i = 0; i < L2; i++) exp_chain2[L2-1-i] = wd2[i];
        hs_base = hs2_cnt;
        d_base  = done2_cnt;
        @(negedge prog_clk);
        start2 = 1'b1;
        @(posedge prog_clk);
        #1;
        start2 = 1'b0;
        c0 = cyc;
        for (int k = 0; k < 2; k++) begin
            cfg_data2  = wd2[k*W +: W];
            cfg_valid2 = 1'b1;
            t = 0;
            do begin @(negedge prog_clk); t++; end while (!cfg_ready2 && t < 60);
            @(posedge prog_clk);
            #1;
        end
        cfg_data2 = 8'h77;
        rdy_late  = 1'b0;
        t = 0;
        while (done2_cnt == d_base && t < 300) begin
            @(posedge prog_clk);
            #2;
            rdy_late = rdy_late | cfg_ready2;
            t++;
        end
        cfg_valid2 = 1'b0;
        check("l16_done_in_time", {31'd0, (t < 300)}, 32'd1);
        check("l16_third_word_stalled", {31'd0, rdy_late}, 32'd0);
        check("l16_words_accepted", hs2_cnt - hs_base, 2);
        check("l16_done_latency", done2_cyc - c0, 2 + 2 * L2);
        check("l16_err", {31'd0, err2}, 32'd0);
        check("l16_chain", {16'd0, chain2}, {16'd0, exp_chain2});

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end
endmodule
